// File: rtl/vwb_arbiter_if.sv
// ----------------------------------------------------------------------------
// vwb_arbiter_if
// Bundles the result-source handshake, the VRF write port, the scoreboard
// release and the arbitration-loss counter of the vector write-back arbiter.
//   slave  modport : the arbiter (samples sources and rf_stall, drives the rest)
//   master modport : the surrounding pipeline / bench (drives sources, rf_stall)
// Packed source fields: source i occupies [i*W +: W] of each src_* vector.
// ----------------------------------------------------------------------------
interface vwb_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 64,
   parameter int VREG_AW = 5,
   parameter int ELEM_AW = 6
);
   logic [NUM_SRC-1:0]         src_valid;
   logic [NUM_SRC-1:0]         src_ready;
   logic [NUM_SRC*VREG_AW-1:0] src_vreg;
   logic [NUM_SRC*ELEM_AW-1:0] src_elem;
   logic [NUM_SRC*DATA_W-1:0]  src_data;
   logic [NUM_SRC-1:0]         src_last;
   logic                       rf_stall;
   logic                       rf_we;
   logic [VREG_AW-1:0]         rf_vreg;
   logic [ELEM_AW-1:0]         rf_elem;
   logic [DATA_W-1:0]          rf_wdata;
   logic                       sb_clr;
   logic [VREG_AW-1:0]         sb_clr_vreg;
   logic [31:0]                conflict_cnt;

   modport slave (
      input  src_valid, src_vreg, src_elem, src_data, src_last, rf_stall,
      output src_ready, rf_we, rf_vreg, rf_elem, rf_wdata,
             sb_clr, sb_clr_vreg, conflict_cnt
   );

   modport master (
      output src_valid, src_vreg, src_elem, src_data, src_last, rf_stall,
      input  src_ready, rf_we, rf_vreg, rf_elem, rf_wdata,
             sb_clr, sb_clr_vreg, conflict_cnt
   );
endinterface

// File: rtl/vwb_arbiter.sv
// ----------------------------------------------------------------------------
// vwb_arbiter
// Vector write-back arbiter: merges NUM_SRC functional-unit result streams
// onto the single VRF write port through a one-entry registered output stage
// that honours rf_stall back-pressure. Round-robin grant, one write per cycle.
// A committed write flagged last releases its vreg on the scoreboard.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : vwb_arbiter_if.slave
//            src_valid/src_ready/src_vreg/src_elem/src_data/src_last (sources)
//            rf_stall (in), rf_we/rf_vreg/rf_elem/rf_wdata (VRF write port)
//            sb_clr/sb_clr_vreg (scoreboard release), conflict_cnt
//
// Build option: VWB_PERF_CNT_EN
//   defined   : conflict_cnt counts cycles in which any valid source was not
//               granted (saturating at 32'hFFFF_FFFF)
//   undefined : no counter logic, conflict_cnt tied to zero
// ----------------------------------------------------------------------------
module vwb_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 64,
   parameter int VREG_AW = 5,
   parameter int ELEM_AW = 6
) (
   input  logic clk,
   input  logic reset,
   vwb_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   // output stage and arbitration state
   logic                 rf_we_r;
   logic [VREG_AW-1:0]   rf_vreg_r;
   logic [ELEM_AW-1:0]   rf_elem_r;
   logic [DATA_W-1:0]    rf_wdata_r;
   logic                 last_r;
   logic [PTR_W-1:0]     rr_ptr_r;

   logic                 take_s;
   logic                 gnt_found_s;
   logic [PTR_W-1:0]     gnt_idx_s;
   logic [PTR_W-1:0]     cand_s;
   logic [PTR_W-1:0]     nxt_ptr_s;
   logic [NUM_SRC-1:0]   grant_s;
   logic [VREG_AW-1:0]   sel_vreg_s;
   logic [ELEM_AW-1:0]   sel_elem_s;
   logic [DATA_W-1:0]    sel_data_s;
   logic                 sel_last_s;

   // The stage can accept when empty or when its current write drains now,
   // which is what removes the bubble on stall release.
   assign take_s = !rf_we_r || !bus.rf_stall;

   // Round-robin search: first valid source at or after rr_ptr_r, cyclically.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = '0;
      cand_s      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_SRC);
         if (take_s && !gnt_found_s && bus.src_valid[cand_s]) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = cand_s;
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // One-hot grant vector and field mux for the granted source.
   always_comb begin
      grant_s    = '0;
      sel_vreg_s = '0;
      sel_elem_s = '0;
      sel_data_s = '0;
      sel_last_s = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt_found_s && (gnt_idx_s == PTR_W'(i))) begin
            grant_s[i] = 1'b1;
            sel_vreg_s = bus.src_vreg[i*VREG_AW +: VREG_AW];
            sel_elem_s = bus.src_elem[i*ELEM_AW +: ELEM_AW];
            sel_data_s = bus.src_data[i*DATA_W +: DATA_W];
            sel_last_s = bus.src_last[i];
         end else begin
            grant_s[i] = 1'b0;
         end
      end
   end

   // Pointer moves to the source after the winner, wrapping at NUM_SRC.
   always_comb begin
      if (gnt_idx_s == PTR_W'(NUM_SRC - 1)) begin
         nxt_ptr_s = '0;
      end else begin
         nxt_ptr_s = gnt_idx_s + 1'b1;
      end
   end

   // Output register: loads on grant, empties when taking with no grant,
   // holds everything while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_r    <= 1'b0;
         rf_vreg_r  <= '0;
         rf_elem_r  <= '0;
         rf_wdata_r <= '0;
         last_r     <= 1'b0;
         rr_ptr_r   <= '0;
      end else if (take_s) begin
         rf_we_r <= gnt_found_s;
         if (gnt_found_s) begin
            rf_vreg_r  <= sel_vreg_s;
            rf_elem_r  <= sel_elem_s;
            rf_wdata_r <= sel_data_s;
            last_r     <= sel_last_s;
            rr_ptr_r   <= nxt_ptr_s;
         end
      end
   end

`ifdef VWB_PERF_CNT_EN
   logic        conflict_s;
   logic [31:0] conflict_cnt_r;

   // A cycle counts once if any requesting source lost, however many lost.
   assign conflict_s = |(bus.src_valid & ~grant_s);

   // Saturating arbitration-loss counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_cnt_r <= 32'd0;
      end else if (conflict_s && (conflict_cnt_r != 32'hFFFF_FFFF)) begin
         conflict_cnt_r <= conflict_cnt_r + 32'd1;
      end
   end

   assign bus.conflict_cnt = conflict_cnt_r;
`else
   assign bus.conflict_cnt = 32'd0;
`endif

   assign bus.src_ready   = grant_s;
   assign bus.rf_we       = rf_we_r;
   assign bus.rf_vreg     = rf_vreg_r;
   assign bus.rf_elem     = rf_elem_r;
   assign bus.rf_wdata    = rf_wdata_r;
   // Release fires only in the cycle the final element actually commits.
   assign bus.sb_clr      = rf_we_r && !bus.rf_stall && last_r;
   assign bus.sb_clr_vreg = rf_vreg_r;

endmodule

// File: tb/tb_vwb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vwb_arbiter
// Directed bench for vwb_arbiter. A driver feeds per-source item queues onto
// the source handshake; expected VRF commits are pushed, in hand-derived
// grant order, into a scoreboard queue that a negedge monitor pops and
// compares on every commit (rf_we && !rf_stall).
// ----------------------------------------------------------------------------
module tb_vwb_arbiter;
   localparam int NS = 4;
   localparam int DW = 64;
   localparam int VW = 5;
   localparam int EW = 6;

   typedef struct packed {
      logic [VW-1:0] vreg;
      logic [EW-1:0] elem;
      logic [DW-1:0] data;
      logic          last;
   } item_t;

   logic clk;
   logic reset;
   bit   mon_en;
   int   total;
   int   bad;

   item_t src_q [NS][$];
   item_t sb_q [$];

   vwb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .VREG_AW(VW), .ELEM_AW(EW)) bus ();

   vwb_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .VREG_AW(VW), .ELEM_AW(EW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic item_t mk(input logic [VW-1:0] v, input logic [EW-1:0] e,
                                input logic [DW-1:0] d, input logic l);
      item_t it;
      it.vreg = v;
      it.elem = e;
      it.data = d;
      it.last = l;
      return it;
   endfunction

   task automatic clear_all();
      for (int i = 0; i < NS; i++) src_q[i].delete();
      sb_q.delete();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   // Source driver: retire granted items, present the head of each queue.
   initial begin
      logic [NS-1:0] fire;
      bus.src_valid = '0;
      bus.src_vreg  = '0;
      bus.src_elem  = '0;
      bus.src_data  = '0;
      bus.src_last  = '0;
      forever begin
         @(negedge clk);
         fire = bus.src_valid & bus.src_ready;
         @(posedge clk);
         #1;
         if (reset) fire = '0;
         for (int i = 0; i < NS; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               bus.src_valid[i]          = 1'b1;
               bus.src_vreg[i*VW +: VW]  = src_q[i][0].vreg;
               bus.src_elem[i*EW +: EW]  = src_q[i][0].elem;
               bus.src_data[i*DW +: DW]  = src_q[i][0].data;
               bus.src_last[i]           = src_q[i][0].last;
            end else begin
               bus.src_valid[i]          = 1'b0;
               bus.src_vreg[i*VW +: VW]  = '0;
               bus.src_elem[i*EW +: EW]  = '0;
               bus.src_data[i*DW +: DW]  = '0;
               bus.src_last[i]           = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: every commit must match the next expected write.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (bus.rf_we && !bus.rf_stall) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_commit", {59'd0, bus.rf_vreg}, 64'h1F_FFFF);
            end else begin
               item_t e;
               e = sb_q.pop_front();
               chk("commit_vreg", 64'(bus.rf_vreg), 64'(e.vreg));
               chk("commit_elem", 64'(bus.rf_elem), 64'(e.elem));
               chk("commit_data", bus.rf_wdata, e.data);
               chk("commit_sb_clr", 64'(bus.sb_clr), 64'(e.last));
               if (e.last) chk("commit_sb_vreg", 64'(bus.sb_clr_vreg), 64'(e.vreg));
            end
         end else begin
            chk("sb_clr_idle", 64'(bus.sb_clr), 64'd0);
         end
      end
   end

   initial begin
      item_t it;
      int    n;
      int    pulses;
      logic [31:0] exp_cnt6;
      total  = 0;
      bad    = 0;
      mon_en = 1'b0;
      reset  = 1'b1;
      bus.rf_stall = 1'b0;
`ifdef VWB_PERF_CNT_EN
      exp_cnt6 = 32'd6;
`else
      exp_cnt6 = 32'd0;
`endif

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("rst_rf_vreg", 64'(bus.rf_vreg), 64'd0);
      chk("rst_rf_wdata", bus.rf_wdata, 64'd0);
      chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
      chk("rst_sb_clr", 64'(bus.sb_clr), 64'd0);
      chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
      @(posedge clk);
      #2;
      reset  = 1'b0;
      mon_en = 1'b1;

      // single source, four elements, latency and back-to-back throughput
      @(posedge clk);
      #2;
      for (int k = 0; k < 4; k++) begin
         it = mk(5'd3, 6'(k), 64'h100 + 64'(k), (k == 3));
         src_q[0].push_back(it);
         sb_q.push_back(it);
      end
      @(negedge clk);
      chk("t1_we_pre", 64'(bus.rf_we), 64'd0);
      @(negedge clk);
      chk("t1_ready", 64'(bus.src_ready), 64'b0001);
      chk("t1_we_grant_cycle", 64'(bus.rf_we), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t1_we_run", 64'(bus.rf_we), 64'd1);
         chk("t1_elem", 64'(bus.rf_elem), 64'(k));
      end
      @(negedge clk);
      chk("t1_we_end", 64'(bus.rf_we), 64'd0);
      drain();

      // fairness from reset, all four sources continuously valid
      @(posedge clk);
      #2;
      reset = 1'b1;
      clear_all();
      @(posedge clk);
      #2;
      reset = 1'b0;
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < 3; k++)
            src_q[s].push_back(mk(5'(8 + s), 6'(k), {32'(s), 32'(k)}, 1'b0));
      for (int k = 0; k < 3; k++)
         for (int s = 0; s < NS; s++)
            sb_q.push_back(mk(5'(8 + s), 6'(k), {32'(s), 32'(k)}, 1'b0));
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         if (bus.rf_we && !bus.rf_stall) begin
            n++;
            if (n == 6) chk("t2_cnt_after6", 64'(bus.conflict_cnt), 64'(exp_cnt6));
         end
      end
      chk("t2_grants_seen", 64'(n), 64'd6);
      drain();

      // stall holds the write, release commits and grants in the same cycle
      @(posedge clk);
      #2;
      bus.rf_stall = 1'b1;
      src_q[1].push_back(mk(5'd7, 6'd2, 64'hAAAA, 1'b0));
      src_q[3].push_back(mk(5'd4, 6'd0, 64'hBBBB, 1'b1));
      sb_q.push_back(mk(5'd7, 6'd2, 64'hAAAA, 1'b0));
      sb_q.push_back(mk(5'd4, 6'd0, 64'hBBBB, 1'b1));
      @(negedge clk);
      @(negedge clk);
      chk("t3_ready_first", 64'(bus.src_ready), 64'b0010);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_hold_we", 64'(bus.rf_we), 64'd1);
         chk("t3_hold_vreg", 64'(bus.rf_vreg), 64'd7);
         chk("t3_hold_data", bus.rf_wdata, 64'hAAAA);
         chk("t3_hold_ready", 64'(bus.src_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      bus.rf_stall = 1'b0;
      @(negedge clk);
      chk("t3_release_ready", 64'(bus.src_ready), 64'b1000);
      chk("t3_release_we", 64'(bus.rf_we), 64'd1);
      drain();

      // scoreboard release only on the last element
      @(posedge clk);
      #2;
      src_q[2].push_back(mk(5'd9, 6'd0, 64'h9000, 1'b0));
      src_q[2].push_back(mk(5'd9, 6'd1, 64'h9001, 1'b1));
      sb_q.push_back(mk(5'd9, 6'd0, 64'h9000, 1'b0));
      sb_q.push_back(mk(5'd9, 6'd1, 64'h9001, 1'b1));
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.sb_clr) begin
            pulses++;
            chk("t4_sb_vreg", 64'(bus.sb_clr_vreg), 64'd9);
         end
      end
      chk("t4_pulses", 64'(pulses), 64'd1);
      drain();

      // reset while a write is held under stall
      @(posedge clk);
      #2;
      bus.rf_stall = 1'b1;
      src_q[0].push_back(mk(5'd5, 6'd0, 64'h5555, 1'b1));
      sb_q.push_back(mk(5'd5, 6'd0, 64'h5555, 1'b1));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("t5_held_we", 64'(bus.rf_we), 64'd1);
      chk("t5_held_vreg", 64'(bus.rf_vreg), 64'd5);
      @(posedge clk);
      #2;
      reset = 1'b1;
      clear_all();
      @(posedge clk);
      #2;
      reset = 1'b0;
      bus.rf_stall = 1'b0;
      @(negedge clk);
      chk("t5_rst_we", 64'(bus.rf_we), 64'd0);
      chk("t5_rst_sb_clr", 64'(bus.sb_clr), 64'd0);
      chk("t5_rst_cnt", 64'(bus.conflict_cnt), 64'd0);
      chk("t5_rst_vreg", 64'(bus.rf_vreg), 64'd0);
      // pointer back at 0: source 0 must beat source 2
      @(posedge clk);
      #2;
      src_q[2].push_back(mk(5'd10, 6'd0, 64'hA0, 1'b0));
      src_q[0].push_back(mk(5'd11, 6'd0, 64'hB0, 1'b0));
      sb_q.push_back(mk(5'd11, 6'd0, 64'hB0, 1'b0));
      sb_q.push_back(mk(5'd10, 6'd0, 64'hA0, 1'b0));
      drain();

      chk("final_queue_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
